display_arbiter: RTL and testbench

// - Shares the six-digit 7-segment display between three requesters:
//   0 = alert (highest priority), 1 = keypad entry, 2 = status/idle (lowest).
// - Drives bcd_packet and enable into the six-digit 7-seg controller.
// - Enforces a minimum hold time per owner, inserts a blank gap on every owner switch,
//   and optionally blinks the alert owner.

---
 rtl/display_arbiter_if.sv | 23 ++
 rtl/display_arbiter.sv | 171 +++++++++++++++++
 tb/tb_display_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/display_arbiter_if.sv
// Request/data bundle from the three display requesters and the arbiter's display-side outputs.
// Latency: none (wires only).
// Backpressure: none; requests are level-sensitive and held by the requesters.
interface display_arbiter_if;
  logic [2:0]  req;
  logic [23:0] data0;
  logic [23:0] data1;
  logic [23:0] data2;
  logic [2:0]  grant;
  logic [23:0] bcd_packet;
  logic        disp_en;
  logic        busy;

  modport master (
    output req, data0, data1, data2,
    input  grant, bcd_packet, disp_en, busy
  );

  modport slave (
    input  req, data0, data1, data2,
    output grant, bcd_packet, disp_en, busy
  );
endinterface

// File: rtl/display_arbiter.sv
// Shares the six-digit 7-seg display among alert/keypad/status requesters with hold, blank gap and alert blink.
// Latency: grant one cycle after the last gap cycle; bcd_packet follows the owner's data one cycle later.
// Backpressure: none; a pending release or preempt is deferred until the owner has held for MIN_HOLD cycles.
module display_arbiter #(
  parameter int MIN_HOLD     = 16,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_HALF   = 8,
  parameter int BLINK_EN     = 1
) (
  input logic              clk,
  input logic              rst,
  display_arbiter_if.slave bus
);

  localparam int HOLD_W  = $clog2(MIN_HOLD + 1);
  localparam int GAP_W   = $clog2(BLANK_CYCLES + 1);
  localparam int BLINK_W = $clog2(BLINK_HALF + 1);

  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(MIN_HOLD);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(BLANK_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [23:0]        BLANK_PKT  = 24'hFFFFFF;
  localparam bit                 BLINK_ON   = (BLINK_EN != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_OWN
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [BLINK_W-1:0]  blink_q, blink_d;
  logic                show_q, show_d;
  logic [2:0]          grant_q, grant_d;
  logic [23:0]         pkt_q, pkt_d;
  logic                busy_q, busy_d;
  logic                en_q;

  logic [1:0]  pick;
  logic [23:0] own_dat;
  logic        own_req;
  logic        preempt;
  logic        blink_active;

  // Lowest index wins among simultaneous requests.
  always_comb begin
    pick = 2'd2;
    if (bus.req[0])      pick = 2'd0;
    else if (bus.req[1]) pick = 2'd1;
  end

  always_comb begin
    own_dat = bus.data2;
    own_req = bus.req[2];
    preempt = bus.req[0] | bus.req[1];
    case (owner_q)
      2'd0: begin
        own_dat = bus.data0;
        own_req = bus.req[0];
        preempt = 1'b0;
      end
      2'd1: begin
        own_dat = bus.data1;
        own_req = bus.req[1];
        preempt = bus.req[0];
      end
      default: ;
    endcase
  end

  assign blink_active = BLINK_ON && (owner_q == 2'd0);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    blink_d = blink_q;
    show_d  = show_q;
    grant_d = grant_q;
    pkt_d   = pkt_q;
    case (state_q)
      S_IDLE: begin
        grant_d = 3'b000;
        pkt_d   = BLANK_PKT;
        if (|bus.req) begin
          state_d = S_BLANK;
          gap_d   = '0;
        end
      end
      S_BLANK: begin
        grant_d = 3'b000;
        pkt_d   = BLANK_PKT;
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (|bus.req) begin
            state_d = S_OWN;
            owner_d = pick;
            grant_d = 3'b001 << pick;
            hold_d  = '0;
            blink_d = '0;
            show_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_OWN: begin
        // Release/preempt is only honoured once the hold counter has saturated.
        if ((hold_q == HOLD_MAX) && (!own_req || preempt)) begin
          state_d = S_BLANK;
          gap_d   = '0;
          grant_d = 3'b000;
          pkt_d   = BLANK_PKT;
        end else begin
          if (hold_q != HOLD_MAX) hold_d = hold_q + HOLD_W'(1);
          if (own_req) pkt_d = (blink_active && !show_q) ? BLANK_PKT : own_dat;
          if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            show_d  = ~show_q;
          end else begin
            blink_d = blink_q + BLINK_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 3'b000;
        pkt_d   = BLANK_PKT;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      owner_q <= 2'd0;
      hold_q  <= '0;
      gap_q   <= '0;
      blink_q <= '0;
      show_q  <= 1'b0;
      grant_q <= 3'b000;
      pkt_q   <= BLANK_PKT;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      blink_q <= blink_d;
      show_q  <= show_d;
      grant_q <= grant_d;
      pkt_q   <= pkt_d;
      busy_q  <= busy_d;
      en_q    <= 1'b1;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.bcd_packet = pkt_q;
  assign bus.busy       = busy_q;
  assign bus.disp_en    = en_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Randomized and directed bench for display_arbiter against a mode/age reference model.
module tb_display_arbiter;

  localparam int MIN_HOLD     = 16;
  localparam int BLANK_CYCLES = 2;
  localparam int BLINK_HALF   = 8;
  localparam int BLINK_EN     = 1;
  localparam logic [23:0] BLANK = 24'hFFFFFF;

  logic clk;
  logic rst;

  display_arbiter_if u_if();

  display_arbiter #(
    .MIN_HOLD    (MIN_HOLD),
    .BLANK_CYCLES(BLANK_CYCLES),
    .BLINK_HALF  (BLINK_HALF),
    .BLINK_EN    (BLINK_EN)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: mode 0 idle, 1 gap, 2 owned; age counts edges since mode entry.
  int          m_mode  = 0;
  int          m_age   = 0;
  int          m_owner = 0;
  logic [23:0] m_pkt   = 24'hFFFFFF;
  logic        m_en    = 1'b0;

  always @(posedge clk or negedge rst) begin
    logic [23:0] d [3];
    logic [2:0]  r;
    bit          pre;
    if (!rst) begin
      m_mode  = 0;
      m_age   = 0;
      m_owner = 0;
      m_pkt   = BLANK;
      m_en    = 1'b0;
    end else begin
      r    = u_if.req;
      d[0] = u_if.data0;
      d[1] = u_if.data1;
      d[2] = u_if.data2;
      m_en = 1'b1;
      case (m_mode)
        0: if (r != 3'b000) begin
          m_mode = 1;
          m_age  = 0;
        end
        1: if (m_age == BLANK_CYCLES - 1) begin
          if (r != 3'b000) begin
            m_mode  = 2;
            m_age   = 0;
            m_owner = r[0] ? 0 : (r[1] ? 1 : 2);
          end else begin
            m_mode = 0;
          end
        end else begin
          m_age++;
        end
        default: begin
          pre = 1'b0;
          for (int j = 0; j < m_owner; j++) if (r[j]) pre = 1'b1;
          if (m_age >= MIN_HOLD && (!r[m_owner] || pre)) begin
            m_mode = 1;
            m_age  = 0;
            m_pkt  = BLANK;
          end else begin
            if (r[m_owner]) begin
              if (m_owner == 0 && BLINK_EN != 0 && ((m_age / BLINK_HALF) % 2) == 1)
                m_pkt = BLANK;
              else
                m_pkt = d[m_owner];
            end
            m_age++;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [2:0] g;
    g = (m_mode == 2) ? (3'b001 << m_owner) : 3'b000;
    chk("model_grant", {21'd0, u_if.grant}, {21'd0, g});
    chk("model_packet", u_if.bcd_packet, m_pkt);
    chk("model_disp_en", {23'd0, u_if.disp_en}, {23'd0, m_en});
    chk("model_busy", {23'd0, u_if.busy}, {23'd0, (m_mode != 0)});
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, {21'd0, u_if.grant}, 24'd0);
    chk({tag, "_packet"}, u_if.bcd_packet, BLANK);
    chk({tag, "_disp_en"}, {23'd0, u_if.disp_en}, 24'd0);
    chk({tag, "_busy"}, {23'd0, u_if.busy}, 24'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] r;
    u_if.req   = 3'b000;
    u_if.data0 = 24'h0;
    u_if.data1 = 24'h0;
    u_if.data2 = 24'h0;
    rst = 1'b1;
    #1 rst = 1'b0;
    adv(3);
    chk_reset_vals("reset");
    rst = 1'b1;
    adv(1);
    chk("en_after_release", {23'd0, u_if.disp_en}, 24'd1);
    chk("idle_busy", {23'd0, u_if.busy}, 24'd0);

    // Single keypad request; edge e0 is the next rising edge.
    u_if.req   = 3'b010;
    u_if.data0 = 24'h000000;
    u_if.data1 = 24'h123456;
    u_if.data2 = 24'h654321;
    adv(1);
    chk("gap0_busy", {23'd0, u_if.busy}, 24'd1);
    chk("gap0_grant", {21'd0, u_if.grant}, 24'd0);
    adv(1);
    chk("gap1_grant", {21'd0, u_if.grant}, 24'd0);
    adv(1);
    chk("own1_grant", {21'd0, u_if.grant}, 24'h2);
    chk("own1_pkt_lag", u_if.bcd_packet, BLANK);
    adv(1);
    chk("own1_pkt", u_if.bcd_packet, 24'h123456);

    // Alert raised at T+3 (T = e2); must wait for the hold.
    adv(1);
    u_if.req = 3'b011;
    adv(14);
    chk("hold_grant_T16", {21'd0, u_if.grant}, 24'h2);
    adv(1);
    chk("preempt_gap_grant", {21'd0, u_if.grant}, 24'd0);
    chk("preempt_gap_busy", {23'd0, u_if.busy}, 24'd1);
    adv(1);
    chk("preempt_gap2_grant", {21'd0, u_if.grant}, 24'd0);
    adv(1);
    chk("alert_grant", {21'd0, u_if.grant}, 24'h1);
    adv(1);
    chk("blink_e22", u_if.bcd_packet, 24'h000000);

    // Alert held while req[2] toggles; packet blinks every BLINK_HALF cycles.
    for (int k = 23; k <= 45; k++) begin
      u_if.req = {k[0], 1'b1, 1'b1};
      adv(1);
      chk("lowprio_grant", {21'd0, u_if.grant}, 24'h1);
      chk("blink_pkt", u_if.bcd_packet, (((k - 22) / BLINK_HALF) % 2 == 1) ? BLANK : 24'h000000);
    end

    u_if.req = 3'b000;
    adv(1);
    chk("rel0_grant", {21'd0, u_if.grant}, 24'd0);
    chk("rel0_pkt", u_if.bcd_packet, BLANK);
    adv(2);
    chk("rel0_idle_busy", {23'd0, u_if.busy}, 24'd0);

    // Status owner released after hold.
    u_if.req = 3'b100;
    adv(3);
    chk("own2_grant", {21'd0, u_if.grant}, 24'h4);
    adv(1);
    chk("own2_pkt", u_if.bcd_packet, 24'h654321);
    adv(18);
    u_if.req = 3'b000;
    adv(1);
    chk("rel2_grant", {21'd0, u_if.grant}, 24'd0);
    chk("rel2_busy", {23'd0, u_if.busy}, 24'd1);
    adv(2);
    chk("rel2_idle_busy", {23'd0, u_if.busy}, 24'd0);
    chk("rel2_idle_pkt", u_if.bcd_packet, BLANK);

    // Randomized traffic with sticky request levels and occasional async reset.
    r = 3'b000;
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 11) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 299) == 0) r = 3'b000;
      u_if.req = r;
      if ($urandom_range(0, 3) == 0) u_if.data0 = 24'($urandom);
      if ($urandom_range(0, 3) == 0) u_if.data1 = 24'($urandom);
      if ($urandom_range(0, 3) == 0) u_if.data2 = 24'($urandom);
      if ($urandom_range(0, 249) == 0) begin
        #1 rst = 1'b0;
        #1 chk_reset_vals("midop_reset");
        adv(1);
        rst = 1'b1;
      end
      adv(1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
